// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall, flush and stall counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [CTRL_W-1:0] ctl_q, ctl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = vld_q & out_ready & ~stall & ~flush;

`ifdef PIPE_SKID_EN
  logic              rdy_q;
  logic              skv_q, skv_d;
  logic [DATA_W-1:0] skd_q, skd_d;
  logic [CTRL_W-1:0] skc_q, skc_d;

  assign in_ready = rdy_q & ~skv_q & ~stall;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    ctl_d = ctl_q;
    skv_d = skv_q;
    skd_d = skd_q;
    skc_d = skc_q;
    unique case (1'b1)
      flush: begin
        vld_d = 1'b0;
        dat_d = '0;
        ctl_d = '0;
        skv_d = 1'b0;
        skd_d = '0;
        skc_d = '0;
      end
      stall & ~flush: ;
      default: begin
        if (out_fire) begin
          if (skv_q) begin
            dat_d = skd_q;
            ctl_d = skc_q;
            skv_d = 1'b0;
            skd_d = '0;
            skc_d = '0;
          end else if (in_fire) begin
            dat_d = in_data;
            ctl_d = in_ctrl;
          end else begin
            vld_d = 1'b0;
            dat_d = '0;
            ctl_d = '0;
          end
        end else if (in_fire) begin
          // output occupied and not draining: park the beat in the skid
          if (vld_q) begin
            skv_d = 1'b1;
            skd_d = in_data;
            skc_d = in_ctrl;
          end else begin
            vld_d = 1'b1;
            dat_d = in_data;
            ctl_d = in_ctrl;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
      skv_q <= 1'b0;
      skd_q <= '0;
      skc_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      skv_q <= skv_d;
      skd_q <= skd_d;
      skc_q <= skc_d;
    end
  end
`else
  assign in_ready = rst & ~stall & ~flush & (~vld_q | out_ready);

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    ctl_d = ctl_q;
    unique case (1'b1)
      flush: begin
        vld_d = 1'b0;
        dat_d = '0;
        ctl_d = '0;
      end
      stall & ~flush: ;
      default: begin
        if (in_fire) begin
          vld_d = 1'b1;
          dat_d = in_data;
          ctl_d = in_ctrl;
        end else if (out_fire) begin
          vld_d = 1'b0;
          dat_d = '0;
          ctl_d = '0;
        end
      end
    endcase
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (vld_q & (~out_ready | stall) & ~flush & ~(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      ctl_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ctl_q <= ctl_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = dat_q;
  assign out_ctrl  = ctl_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (CNT_W=4).
// Mode-specific in_ready expectations follow PIPE_SKID_EN.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic        cnt_clr;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int fails  = 0;

  pipe_stage_reg #(
    .DATA_W(32),
    .CTRL_W(16),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .cnt_clr  (cnt_clr),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [15:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic tick();
    logic fi;
    #1;
    fi = in_valid & in_ready & ~flush;
    @(posedge clk);
    #1;
    if (fi) in_valid = 1'b0;
  endtask

  logic [31:0] exp_q [2];
  int n;

  initial begin
    rst = 1'b1;
    stall = 0; flush = 0; cnt_clr = 0;
    in_valid = 0; in_data = 0; in_ctrl = 0;
    out_ready = 0;
    #1 rst = 1'b0;
    #1;
    check("rst_vld", out_valid, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rel_rdy", in_ready, 1);

    drive(32'h1234_5678, 16'hABCD);
    tick();
    check("first_vld", out_valid, 1);
    check("first_dat", out_data, 32'h1234_5678);
    check("first_ctl", out_ctrl, 16'hABCD);
    tick();
    check("hold_cnt", stall_cnt, 1);

    rst = 1'b0;
    #1;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_ctl", out_ctrl, 0);
    check("mid_rst_dat", out_data, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    check("mid_rst_rdy", in_ready, 0);
    rst = 1'b1;
    tick();

    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(i, i[15:0]);
      tick();
      check("stream_vld", out_valid, 1);
      check("stream_dat", out_data, i);
      check("stream_ctl", out_ctrl, i);
    end
    tick();
    check("stream_bub_vld", out_valid, 0);
    check("stream_bub_ctl", out_ctrl, 0);
    check("stream_bub_dat", out_data, 0);
    check("stream_cnt", stall_cnt, 0);

    out_ready = 1'b0;
    drive(32'hA1, 16'h00A1);
    tick();
    check("bp_load", out_data, 32'hA1);
    drive(32'hA2, 16'h00A2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", out_data, 32'hA1);
    end
    check("bp_cnt", stall_cnt, 5);
`ifdef PIPE_SKID_EN
    check("bp_skid_rdy", in_ready, 0);
`else
    check("bp_comb_rdy", in_ready, 0);
`endif
    exp_q[0] = 32'hA1;
    exp_q[1] = 32'hA2;
    n = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) begin
        if (n < 2) check("bp_drain", out_data, exp_q[n]);
        n++;
      end
      tick();
    end
    check("bp_beats", n, 2);
    check("bp_cnt_after", stall_cnt, 5);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", stall_cnt, 0);
    out_ready = 1'b0;
    drive(32'hB1, 16'h00B1);
    tick();
    check("fl_pre_vld", out_valid, 1);
    flush = 1'b1;
    stall = 1'b1;
    drive(32'hDEAD, 16'hFFFF);
    #1;
    check("fl_rdy", in_ready, 0);
    tick();
    flush = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    check("fl_vld", out_valid, 0);
    check("fl_ctl", out_ctrl, 0);
    check("fl_dat", out_data, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fl_no_emit", out_valid, 0);
      tick();
    end
    check("fl_cnt", stall_cnt, 0);

    drive(32'hC1, 16'h00C1);
    tick();
    check("st_load", out_data, 32'hC1);
    stall = 1'b1;
    drive(32'hC2, 16'h00C2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_rdy", in_ready, 0);
      tick();
      check("st_vld", out_valid, 1);
      check("st_dat", out_data, 32'hC1);
    end
    check("st_cnt", stall_cnt, 3);
    stall = 1'b0;
    tick();
    check("st_next", out_data, 32'hC2);
    check("st_next_ctl", out_ctrl, 16'h00C2);
    tick();
    check("st_bub", out_valid, 0);
    check("st_cnt_after", stall_cnt, 3);

    cnt_clr = 1'b1;
    out_ready = 1'b0;
    drive(32'hD1, 16'h00D1);
    tick();
    cnt_clr = 1'b0;
    check("sat_start", stall_cnt, 0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", stall_cnt, 15);
    check("sat_dat", out_data, 32'hD1);
    cnt_clr = 1'b1;
    tick();
    check("sat_clr", stall_cnt, 0);
    cnt_clr = 1'b0;
    tick();
    check("sat_resume", stall_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic data bus and control bus between stages under a valid/ready handshake, with stall and flush, and an optional two-entry skid buffer for timing isolation. It also counts backpressure cycles for performance monitoring. One instance sits at every stage boundary of the CPU pipeline.

## Interface
- DATA_W, 32: payload width (operands, PC, immediates, register indices, packed by the instantiating stage).
- CTRL_W, 16: control width (regwrite, memwrite, alucontrol and similar). Zeroed on bubble and flush.
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freeze stage: no accept, no emit.
- flush  in  1  synchronous kill of all contents; priority over stall.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  stage holds a valid beat.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload.
- out_ctrl  out  CTRL_W  control; all-zero whenever out_valid=0.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of backpressure cycles.

## Operation
- Accept: in_fire = in_valid & in_ready & ~flush. Emit: out_fire = out_valid & out_ready & ~stall & ~flush.
- Transfers are in order, with no loss and no duplication. Each beat appears on the output exactly once.
- Flush, cycle N: next cycle out_valid=0, out_data=0, out_ctrl=0, skid empty. The beat offered at N is discarded even if in_ready=1.
- Stall (no flush): all registers hold, in_ready=0, out_valid/out_data/out_ctrl unchanged.
- Bubble: if out_fire and no in_fire, the next cycle has out_valid=0 and out_ctrl=0. out_data is also zeroed.
- stall_cnt increments when out_valid & (~out_ready | stall) and flush=0. It saturates at 2^CNT_W-1 and never wraps.
- cnt_clr forces stall_cnt to 0 next cycle and takes priority over increment. Flush does not clear stall_cnt.
- Reset (async assert, any cycle including mid-transfer):
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, skid empty, immediately.
  - in_ready during reset: 0 in both modes.
  - After release: in_ready=1 in the first cycle (combinational mode, stall=0) or first edge after release (skid mode).

## Timing
- Latency in_fire → out_valid: 1 cycle, both modes.
- Throughput: 1 beat/cycle sustained when out_ready=1 and stall=0.
- Combinational mode: in_ready = ~stall & ~flush & (~out_valid | out_ready). This is a combinational path from out_ready.
- Skid mode: in_ready = ~skid_valid & ~stall, with skid_valid registered. There is no combinational path from out_ready to in_ready.
- Skid fill: if out_valid & ~out_ready & in_fire, the beat goes to the skid entry and in_ready drops next cycle.
- Skid drain: on out_fire with skid full, skid moves to output and in_ready rises next cycle. With skid empty, the output loads in_data directly.
- Simultaneous out_fire and in_fire:
  - skid empty: output takes the new beat, out_valid stays 1.
  - skid full: output takes the skid beat; in_fire is impossible (in_ready=0).

## Configuration
- PIPE_SKID_EN defined: two-entry storage (output + skid), registered in_ready. Up to 2 beats are buffered.
- PIPE_SKID_EN undefined: single register, combinational in_ready as above. Skid logic is absent.
- Port list, latency and all other behaviour are identical in both builds.

## Test plan
- Reset: rst=0 mid-stream with out_valid=1 → out_valid=0, out_ctrl=0, stall_cnt=0 the same cycle. First beat after release (data 0x1234_5678) appears on out_data 1 cycle after in_fire.
- Streaming: 8 beats (data 1..8, ctrl 0x0001..0x0008), out_ready=1 → out_valid high 8 consecutive cycles, values in order, stall_cnt=0.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data held, stall_cnt=5, no beat lost. Skid build: in_ready drops after the 2nd buffered beat.
- Flush priority: flush=1 and stall=1 together with in_valid=1, data 0xDEAD → next cycle out_valid=0, out_ctrl=0, and 0xDEAD never emitted.
- Stall: stall=1 for 3 cycles with out_ready=1 → no in_fire/out_fire, out_data constant, stall_cnt +3.
- Counter saturation: CNT_W=4, 20 backpressure cycles → stall_cnt=15. cnt_clr=1 → 0 next cycle, even with backpressure still asserted.
